// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-8910 compatible PSG: register indices, R13 bits,
// per-register write masks, the 16-entry log volume table and envelope states.
package ay_pkg;

  localparam logic [3:0] AY_R_TONEA_L   = 4'd0;
  localparam logic [3:0] AY_R_TONEA_H   = 4'd1;
  localparam logic [3:0] AY_R_TONEB_L   = 4'd2;
  localparam logic [3:0] AY_R_TONEB_H   = 4'd3;
  localparam logic [3:0] AY_R_TONEC_L   = 4'd4;
  localparam logic [3:0] AY_R_TONEC_H   = 4'd5;
  localparam logic [3:0] AY_R_NOISE     = 4'd6;
  localparam logic [3:0] AY_R_MIXER     = 4'd7;
  localparam logic [3:0] AY_R_AMP_A     = 4'd8;
  localparam logic [3:0] AY_R_AMP_B     = 4'd9;
  localparam logic [3:0] AY_R_AMP_C     = 4'd10;
  localparam logic [3:0] AY_R_ENV_L     = 4'd11;
  localparam logic [3:0] AY_R_ENV_H     = 4'd12;
  localparam logic [3:0] AY_R_ENV_SHAPE = 4'd13;

  localparam int ENV_HOLD = 0;
  localparam int ENV_ALT  = 1;
  localparam int ENV_ATT  = 2;
  localparam int ENV_CONT = 3;

  // Index 0 is the rightmost element of each packed table.
  localparam logic [15:0][7:0] REG_MASK = {
    8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
    8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  localparam logic [15:0][7:0] VOL_TAB = {
    8'hFF, 8'hB4, 8'h80, 8'h5A, 8'h40, 8'h2D, 8'h20, 8'h17,
    8'h10, 8'h0B, 8'h08, 8'h06, 8'h04, 8'h03, 8'h02, 8'h00
  };

  typedef enum logic [1:0] {
    ENV_ATTACK = 2'd0,
    ENV_DECAY  = 2'd1,
    ENV_HELD   = 2'd2
  } env_state_t;

endpackage

// File: rtl/ay_tone_chan.sv
// One AY tone channel: 12-bit period counter that toggles a square wave on expiry.
module ay_tone_chan (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [11:0] period,
  output logic        tone
);

  logic [11:0] cnt;
  logic [11:0] per_eff;
  logic [12:0] cnt_inc;

  assign per_eff = (period == 12'd0) ? 12'd1 : period;
  assign cnt_inc = {1'b0, cnt} + 13'd1;

  // >= rather than == so a period shortened below the current count wraps at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (tick) begin
      if (cnt_inc >= {1'b0, per_eff}) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt  <= cnt_inc[11:0];
      end
    end
  end

endmodule

// File: rtl/ay_psg.sv
// AY-3-8910 compatible PSG on the Z80 I/O bus: 0xFFFD select/readback, 0xBFFD data.
// Define AY_SIGMA_DELTA_EN to drive snd_pin from a first-order sigma-delta DAC.
//
//  state      | meaning
//  ENV_ATTACK | envelope level = step (rising)
//  ENV_DECAY  | envelope level = 15 - step (falling)
//  ENV_HELD   | envelope frozen at env_hold_lvl until R13 is rewritten
module ay_psg
  import ay_pkg::*;
#(
  parameter int CE_DIV = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  output logic [7:0]  D_out,
  output logic        rd_sel,
  output logic [9:0]  sample,
  output logic        snd_pin
);

  localparam int CE_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  logic [CE_W-1:0] ce_cnt;
  logic            ce;
  logic [3:0]      pre_cnt;
  logic            tone_tick;
  logic            noise_tick;

  assign ce         = (ce_cnt == '0);
  assign tone_tick  = ce & (pre_cnt[2:0] == 3'd7);
  assign noise_tick = ce & (pre_cnt == 4'd15);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ce_cnt  <= '0;
      pre_cnt <= '0;
    end else if (ce) begin
      ce_cnt  <= CE_W'(CE_DIV - 1);
      pre_cnt <= pre_cnt + 4'd1;
    end else begin
      ce_cnt  <= ce_cnt - 1'b1;
    end
  end

  // Bus decode and register file
  logic             sel_dec;
  logic             dat_dec;
  logic             wr_now;
  logic             wr_q;
  logic             wr_d;
  logic             wr_pulse;
  logic             reg_we;
  logic             env_wr;
  logic [3:0]       addr;
  logic             addr_valid;
  logic [15:0][7:0] regs;

  assign sel_dec  = A[15] & A[14] & ~A[1];
  assign dat_dec  = A[15] & ~A[14] & ~A[1];
  assign wr_now   = ~nIORQ & ~nWR & nM1;
  assign wr_pulse = wr_q & ~wr_d;
  assign reg_we   = wr_pulse & dat_dec & addr_valid;
  assign env_wr   = reg_we & (addr == AY_R_ENV_SHAPE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      wr_d       <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b1;
      regs       <= '0;
    end else begin
      wr_q <= wr_now;
      wr_d <= wr_q;
      if (wr_pulse & sel_dec) begin
        addr       <= D_in[3:0];
        addr_valid <= (D_in[7:4] == 4'd0);
      end
      if (reg_we) regs[addr] <= D_in & REG_MASK[addr];
    end
  end

  assign rd_sel = ~nIORQ & ~nRD & nM1 & sel_dec;
  assign D_out  = addr_valid ? regs[addr] : 8'hFF;

  // Noise
  logic [4:0]  nz_cnt;
  logic [4:0]  nz_per;
  logic [5:0]  nz_inc;
  logic [16:0] lfsr;
  logic        noise;

  assign nz_per = (regs[AY_R_NOISE][4:0] == 5'd0) ? 5'd1 : regs[AY_R_NOISE][4:0];
  assign nz_inc = {1'b0, nz_cnt} + 6'd1;
  assign noise  = lfsr[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nz_cnt <= '0;
      lfsr   <= 17'h1;
    end else if (noise_tick) begin
      if (nz_inc >= {1'b0, nz_per}) begin
        nz_cnt <= '0;
        lfsr   <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        nz_cnt <= nz_inc[4:0];
      end
    end
  end

  // Envelope
  env_state_t  env_state;
  env_state_t  env_state_nx;
  logic [3:0]  env_step;
  logic [3:0]  env_step_nx;
  logic [3:0]  env_hold_lvl;
  logic [3:0]  env_hold_nx;
  logic [15:0] env_cnt;
  logic [15:0] env_per;
  logic [16:0] env_inc;
  logic        env_exp;
  logic [3:0]  env_level;

  assign env_per = ({regs[AY_R_ENV_H], regs[AY_R_ENV_L]} == 16'd0) ? 16'd1
                   : {regs[AY_R_ENV_H], regs[AY_R_ENV_L]};
  assign env_inc = {1'b0, env_cnt} + 17'd1;
  assign env_exp = tone_tick & (env_inc >= {1'b0, env_per});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      env_cnt      <= '0;
      env_state    <= ENV_DECAY;
      env_step     <= '0;
      env_hold_lvl <= '0;
    end else begin
      if (env_wr)         env_cnt <= '0;
      else if (env_exp)   env_cnt <= '0;
      else if (tone_tick) env_cnt <= env_inc[15:0];
      env_state    <= env_state_nx;
      env_step     <= env_step_nx;
      env_hold_lvl <= env_hold_nx;
    end
  end

  // A shape write takes priority over an expiry landing in the same cycle
  always_comb begin
    env_state_nx = env_state;
    env_step_nx  = env_step;
    env_hold_nx  = env_hold_lvl;
    if (env_wr) begin
      env_step_nx  = '0;
      env_state_nx = D_in[ENV_ATT] ? ENV_ATTACK : ENV_DECAY;
    end else if (env_exp && env_state != ENV_HELD) begin
      if (env_step != 4'd15) begin
        env_step_nx = env_step + 4'd1;
      end else begin
        env_step_nx = '0;
        if (!regs[AY_R_ENV_SHAPE][ENV_CONT]) begin
          env_state_nx = ENV_HELD;
          env_hold_nx  = 4'd0;
        end else if (regs[AY_R_ENV_SHAPE][ENV_HOLD]) begin
          env_state_nx = ENV_HELD;
          env_hold_nx  = {4{(env_state == ENV_ATTACK) ^ regs[AY_R_ENV_SHAPE][ENV_ALT]}};
        end else if (regs[AY_R_ENV_SHAPE][ENV_ALT]) begin
          env_state_nx = (env_state == ENV_ATTACK) ? ENV_DECAY : ENV_ATTACK;
        end
      end
    end
  end

  always_comb begin
    case (env_state)
      ENV_ATTACK: env_level = env_step;
      ENV_DECAY:  env_level = ~env_step;
      default:    env_level = env_hold_lvl;
    endcase
  end

  // Channels, mixer and volume
  logic [2:0]      tone;
  logic [2:0]      mix;
  logic [2:0][7:0] vol;

  for (genvar n = 0; n < 3; n++) begin : g_chan
    logic [3:0] lvl;

    ay_tone_chan u_tone (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tone_tick),
      .period  ({regs[2*n+1][3:0], regs[2*n]}),
      .tone    (tone[n])
    );

    assign mix[n] = (tone[n] | regs[AY_R_MIXER][n]) & (noise | regs[AY_R_MIXER][n+3]);
    assign lvl    = regs[AY_R_AMP_A + n][4] ? env_level : regs[AY_R_AMP_A + n][3:0];
    assign vol[n] = mix[n] ? VOL_TAB[lvl] : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sample <= '0;
    else          sample <= 10'(vol[0]) + 10'(vol[1]) + 10'(vol[2]);
  end

`ifdef AY_SIGMA_DELTA_EN
  logic [10:0] sd_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sd_acc <= '0;
    else          sd_acc <= {1'b0, sd_acc[9:0]} + {1'b0, sample};
  end

  assign snd_pin = sd_acc[10];
`else
  assign snd_pin = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{A, regs};

endmodule
